// File: rtl/axis_output_pipe_pkg.sv
// Shared constants and types for the conv-engine output pipe.
package axis_output_pipe_pkg;

    // Counter width for a ratio; never narrower than one bit.
    function automatic int calc_bits_ratio(input int ratio);
        int bits;
        bits = $clog2(ratio);
        return (bits < 1) ? 1 : bits;
    endfunction

    localparam int CORES                = 4;
    localparam int UNITS                = 8;
    localparam int WORD_WIDTH_ACC       = 32;
    localparam int M_DATA_WORDS         = 4;

    localparam int S_WORDS              = CORES * UNITS;
    localparam int RATIO                = S_WORDS / M_DATA_WORDS;
    localparam int BITS_RATIO           = calc_bits_ratio(RATIO);

    // Conv-output tuser flags.
    localparam int TUSER_WIDTH_CONV_OUT = 4;
    localparam int I_IS_CONFIG          = 0;

    // Full flag doubles as the state: either waiting for a beat or walking through one.
    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_SHIFTING = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/axis_output_pipe.sv
// Serializes one wide conv-engine result beat into RATIO narrow AXI-Stream beats.
// The data register is loaded once per input beat and never shifts; a word-select
// mux driven by the beat counter picks the slice presented to the DMA.
module axis_output_pipe #(
    parameter int CORES                = axis_output_pipe_pkg::CORES,
    parameter int UNITS                = axis_output_pipe_pkg::UNITS,
    parameter int WORD_WIDTH_ACC       = axis_output_pipe_pkg::WORD_WIDTH_ACC,
    parameter int M_DATA_WORDS         = axis_output_pipe_pkg::M_DATA_WORDS,
    parameter int TUSER_WIDTH_CONV_OUT = axis_output_pipe_pkg::TUSER_WIDTH_CONV_OUT,
    parameter int I_IS_CONFIG          = axis_output_pipe_pkg::I_IS_CONFIG,
    localparam int S_WORDS             = CORES * UNITS,
    localparam int RATIO               = S_WORDS / M_DATA_WORDS,
    localparam int BITS_RATIO          = axis_output_pipe_pkg::calc_bits_ratio(RATIO)
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    output logic [BITS_RATIO:0]                      debug_config,
    output logic                                     s_axis_tready,
    input  logic                                     s_axis_tvalid,
    input  logic                                     s_axis_tlast,
    input  logic [WORD_WIDTH_ACC*S_WORDS-1:0]        s_axis_tdata,
    input  logic [TUSER_WIDTH_CONV_OUT-1:0]          s_axis_tuser,
    input  logic                                     m_axis_tready,
    output logic                                     m_axis_tvalid,
    output logic                                     m_axis_tlast,
    output logic [WORD_WIDTH_ACC*M_DATA_WORDS-1:0]   m_axis_tdata,
    output logic [WORD_WIDTH_ACC*M_DATA_WORDS/8-1:0] m_axis_tkeep
);
    import axis_output_pipe_pkg::*;

    localparam int DATA_W = WORD_WIDTH_ACC * S_WORDS;
    localparam int BEAT_W = WORD_WIDTH_ACC * M_DATA_WORDS;
    localparam int KEEP_W = BEAT_W / 8;
    localparam logic [BITS_RATIO-1:0] LAST_CNT = BITS_RATIO'(RATIO - 1);
    localparam logic [BITS_RATIO-1:0] ZERO_CNT = {BITS_RATIO{1'b0}};

    pipe_state_e              state_q, state_d;
    logic [BITS_RATIO-1:0]    count_q, count_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     last_q, last_d;

    logic                     full_s;
    logic                     last_beat_s;
    logic                     out_hs_s;
    logic                     out_done_s;
    logic                     s_ready_s;
    logic                     s_in_s;
    logic                     data_in_s;
    logic [BEAT_W-1:0]        tdata_s;
    logic                     unused_tuser_s;

    // Handshake decode: tready from the DMA reaches only s_axis_tready.
    always_comb begin
        full_s         = (state_q == ST_SHIFTING);
        last_beat_s    = (count_q == LAST_CNT);
        out_hs_s       = full_s && m_axis_tready;
        out_done_s     = out_hs_s && last_beat_s;
        s_ready_s      = !full_s || out_done_s;
        s_in_s         = s_axis_tvalid && s_ready_s;
        data_in_s      = s_in_s && !s_axis_tuser[I_IS_CONFIG];
        unused_tuser_s = ^s_axis_tuser;
    end

    // Next state: load on a data beat (reload wins over drain), else drain or advance.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        last_d  = last_q;
        if (data_in_s) begin
            state_d = ST_SHIFTING;
            count_d = ZERO_CNT;
            data_d  = s_axis_tdata;
            last_d  = s_axis_tlast;
        end else if (out_done_s) begin
            state_d = ST_EMPTY;
            count_d = ZERO_CNT;
        end else if (out_hs_s) begin
            count_d = count_q + BITS_RATIO'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State, counter and beat storage; reset drops any partially sent beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_EMPTY;
            count_q <= ZERO_CNT;
            data_q  <= {DATA_W{1'b0}};
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Word-select mux: the counter picks which slice of the held beat goes out.
    always_comb begin
        tdata_s = {BEAT_W{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            tdata_s = (count_q == BITS_RATIO'(i)) ? data_q[i*BEAT_W +: BEAT_W] : tdata_s;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tvalid = full_s;
    assign m_axis_tlast  = full_s && last_q && last_beat_s;
    assign m_axis_tdata  = tdata_s;
    assign m_axis_tkeep  = {KEEP_W{1'b1}};
    assign debug_config  = {full_s, count_q};

endmodule

// File: tb/tb_axis_output_pipe.sv
// Scoreboard bench: drivers push expected narrow beats, monitors pop and compare.
module tb_axis_output_pipe;
    localparam int R  = 8;
    localparam int DW = 1024;
    localparam int BW = 128;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // DUT A: default build, RATIO = 8
    logic [3:0]    a_dbg;
    logic          s_tready_a, s_tvalid_a, s_tlast_a, m_tready_a, m_tvalid_a, m_tlast_a;
    logic [DW-1:0] s_tdata_a;
    logic [3:0]    s_tuser_a;
    logic [BW-1:0] m_tdata_a;
    logic [15:0]   m_tkeep_a;

    // DUT B: RATIO = 1 build
    logic [1:0]    b_dbg;
    logic          s_tready_b, s_tvalid_b, s_tlast_b, m_tready_b, m_tvalid_b, m_tlast_b;
    logic [DW-1:0] s_tdata_b;
    logic [3:0]    s_tuser_b;
    logic [DW-1:0] m_tdata_b;
    logic [127:0]  m_tkeep_b;

    axis_output_pipe u_dut_a (
        .aclk(aclk), .aresetn(aresetn), .debug_config(a_dbg),
        .s_axis_tready(s_tready_a), .s_axis_tvalid(s_tvalid_a), .s_axis_tlast(s_tlast_a),
        .s_axis_tdata(s_tdata_a), .s_axis_tuser(s_tuser_a),
        .m_axis_tready(m_tready_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tlast(m_tlast_a),
        .m_axis_tdata(m_tdata_a), .m_axis_tkeep(m_tkeep_a)
    );

    axis_output_pipe #(.M_DATA_WORDS(32)) u_dut_b (
        .aclk(aclk), .aresetn(aresetn), .debug_config(b_dbg),
        .s_axis_tready(s_tready_b), .s_axis_tvalid(s_tvalid_b), .s_axis_tlast(s_tlast_b),
        .s_axis_tdata(s_tdata_b), .s_axis_tuser(s_tuser_b),
        .m_axis_tready(m_tready_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tlast(m_tlast_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b)
    );

    typedef struct packed { logic [BW-1:0] d; logic l; } beat_a_t;
    typedef struct packed { logic [DW-1:0] d; logic l; } beat_b_t;
    beat_a_t qa[$];
    beat_b_t qb[$];

    int checks = 0;
    int errors = 0;
    int hs_a = 0, hs_b = 0;
    int run_a = 0, max_run_a = 0, last_hs_cyc_a = -10;
    int mode_a = 0, mode_b = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // DMA-side ready generators: 0 = always ready, 1 = pattern 1,0,0, 2 = random
    initial begin
        int tog;
        tog = 0;
        m_tready_a = 1'b1;
        forever begin
            @(posedge aclk); #1;
            case (mode_a)
                0: m_tready_a = 1'b1;
                1: begin m_tready_a = (tog == 0); tog = (tog + 1) % 3; end
                default: m_tready_a = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        m_tready_b = 1'b1;
        forever begin
            @(posedge aclk); #1;
            m_tready_b = (mode_b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor A: scoreboard compare plus AXI hold rules under backpressure
    initial begin
        logic          stall;
        logic [BW-1:0] prev_d;
        logic [3:0]    prev_dbg;
        beat_a_t       e;
        stall = 1'b0;
        prev_d = '0;
        prev_dbg = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid_a", m_tvalid_a, 1'b1);
                    chk("hold_data_a", m_tdata_a, prev_d);
                    chk("hold_count_a", a_dbg, prev_dbg);
                end
                if (m_tvalid_a && m_tready_a) begin
                    hs_a++;
                    run_a = (last_hs_cyc_a == cyc - 1) ? run_a + 1 : 1;
                    if (run_a > max_run_a) max_run_a = run_a;
                    last_hs_cyc_a = cyc;
                    chk("tkeep_a", m_tkeep_a, 16'hFFFF);
                    if (qa.size() == 0) begin
                        chk("spurious_valid_a", m_tvalid_a, 1'b0);
                    end else begin
                        e = qa.pop_front();
                        chk("data_a", m_tdata_a, e.d);
                        chk("last_a", m_tlast_a, e.l);
                    end
                end
                stall = m_tvalid_a && !m_tready_a;
                prev_d = m_tdata_a;
                prev_dbg = a_dbg;
            end
        end
    end

    // Monitor B: RATIO=1 output must equal the input beat
    initial begin
        beat_b_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && m_tvalid_b && m_tready_b) begin
                hs_b++;
                if (qb.size() == 0) begin
                    chk("spurious_valid_b", m_tvalid_b, 1'b0);
                end else begin
                    e = qb.pop_front();
                    chk("data_b_lo", m_tdata_b[511:0], e.d[511:0]);
                    chk("data_b_hi", m_tdata_b[1023:512], e.d[1023:512]);
                    chk("last_b", m_tlast_b, e.l);
                end
            end
        end
    end

    // Offer one beat to DUT A; on acceptance push the RATIO expected narrow beats
    task automatic send_a(input logic [DW-1:0] d, input logic [3:0] u, input logic l,
                          output int acc_cyc);
        bit ok;
        beat_a_t e;
        ok = 1'b0;
        acc_cyc = -1;
        s_tvalid_a = 1'b1; s_tdata_a = d; s_tuser_a = u; s_tlast_a = l;
        for (int t = 0; t < 300; t++) begin
            @(negedge aclk);
            if (s_tready_a) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout_a", s_tready_a, 1'b1);
        end else begin
            acc_cyc = cyc;
            if (!u[0]) begin
                for (int i = 0; i < R; i++) begin
                    e.d = d[i*BW +: BW];
                    e.l = l && (i == R - 1);
                    qa.push_back(e);
                end
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic send_b(input logic [DW-1:0] d, input logic l);
        bit ok;
        beat_b_t e;
        ok = 1'b0;
        s_tvalid_b = 1'b1; s_tdata_b = d; s_tuser_b = 4'h0; s_tlast_b = l;
        for (int t = 0; t < 300; t++) begin
            @(negedge aclk);
            if (s_tready_b) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout_b", s_tready_b, 1'b1);
        end else begin
            e.d = d; e.l = l;
            qb.push_back(e);
        end
        @(posedge aclk); #1;
    endtask

    task automatic drain_a();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge aclk);
            if (qa.size() == 0 && !m_tvalid_a) begin ok = 1'b1; break; end
        end
        if (!ok) chk("drain_timeout_a", qa.size(), 0);
        @(posedge aclk); #1;
    endtask

    task automatic drain_b();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge aclk);
            if (qb.size() == 0 && !m_tvalid_b) begin ok = 1'b1; break; end
        end
        if (!ok) chk("drain_timeout_b", qb.size(), 0);
        @(posedge aclk); #1;
    endtask

    function automatic logic [DW-1:0] rand_words();
        logic [DW-1:0] d;
        for (int k = 0; k < 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        int acc0, acc1, acc2, c0, hs0;
        bit ok;
        s_tvalid_a = 1'b0; s_tdata_a = '0; s_tuser_a = '0; s_tlast_a = 1'b0;
        s_tvalid_b = 1'b0; s_tdata_b = '0; s_tuser_b = '0; s_tlast_b = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_valid_a", m_tvalid_a, 1'b0);
        chk("reset_last_a", m_tlast_a, 1'b0);
        chk("reset_dbg_a", a_dbg, 4'h0);
        chk("reset_valid_b", m_tvalid_b, 1'b0);
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("reset_s_tready_a", s_tready_a, 1'b1);

        // Single beat of words k=k, tlast set
        for (int k = 0; k < 32; k++) d[k*32 +: 32] = 32'(k);
        send_a(d, 4'h0, 1'b1, acc0);
        s_tvalid_a = 1'b0;
        for (int i = 1; i <= R; i++) begin
            @(negedge aclk);
            chk("s_tready_busy_a", s_tready_a, (i == R));
        end
        @(posedge aclk); #1;
        drain_a();

        // Three back-to-back beats with tvalid held high
        max_run_a = 0;
        hs0 = hs_a;
        send_a(rand_words(), 4'h0, 1'b0, acc0);
        send_a(rand_words(), 4'h0, 1'b0, acc1);
        send_a(rand_words(), 4'h0, 1'b1, acc2);
        s_tvalid_a = 1'b0;
        drain_a();
        chk("b2b_reload_gap1", acc1 - acc0, R);
        chk("b2b_reload_gap2", acc2 - acc1, R);
        chk("b2b_no_bubble", max_run_a, 3 * R);
        chk("b2b_count", hs_a - hs0, 3 * R);

        // Config beat between two data beats
        hs0 = hs_a;
        send_a(rand_words(), 4'h0, 1'b0, acc0);
        s_tvalid_a = 1'b0;
        drain_a();
        c0 = cyc;
        send_a(rand_words(), 4'h1, 1'b1, acc1);
        s_tvalid_a = 1'b0;
        chk("cfg_one_cycle", acc1 - c0, 0);
        @(negedge aclk);
        chk("cfg_no_output", m_tvalid_a, 1'b0);
        @(posedge aclk); #1;
        send_a(rand_words(), 4'h0, 1'b1, acc2);
        s_tvalid_a = 1'b0;
        drain_a();
        chk("cfg_total_beats", hs_a - hs0, 2 * R);

        // Backpressure pattern 1,0,0
        mode_a = 1;
        hs0 = hs_a;
        send_a(rand_words(), 4'h0, 1'b1, acc0);
        s_tvalid_a = 1'b0;
        drain_a();
        chk("bp_count", hs_a - hs0, R);
        mode_a = 0;
        repeat (2) @(posedge aclk);
        #1;

        // Reset after 3 of 8 beats
        hs0 = hs_a;
        send_a(rand_words(), 4'h0, 1'b1, acc0);
        s_tvalid_a = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge aclk);
            if (hs_a - hs0 >= 3) begin ok = 1'b1; break; end
        end
        if (!ok) chk("rst_wait_timeout", hs_a - hs0, 3);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_async_valid", m_tvalid_a, 1'b0);
        chk("rst_async_dbg", a_dbg, 4'h0);
        qa.delete();
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("rst_s_tready", s_tready_a, 1'b1);
        send_a(rand_words(), 4'h0, 1'b1, acc0);
        s_tvalid_a = 1'b0;
        drain_a();

        // Randomized traffic with random backpressure, config beats and gaps
        mode_a = 2;
        for (int n = 0; n < 20; n++) begin
            send_a(rand_words(), ($urandom_range(0, 4) == 0) ? 4'h1 : 4'(($urandom_range(0, 7)) << 1),
                   1'($urandom_range(0, 1)), acc0);
            if ($urandom_range(0, 2) == 0) begin
                s_tvalid_a = 1'b0;
                repeat ($urandom_range(1, 12)) @(posedge aclk);
                #1;
            end
        end
        s_tvalid_a = 1'b0;
        drain_a();

        // RATIO=1 build: 5 back-to-back beats, random ready
        mode_b = 1;
        hs0 = hs_b;
        for (int n = 0; n < 5; n++) send_b(rand_words(), (n == 4));
        s_tvalid_b = 1'b0;
        drain_b();
        chk("r1_count", hs_b - hs0, 5);
        chk("r1_tkeep", m_tkeep_b, {128{1'b1}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
